// File: rtl/store_size_rmw.sv
// store_size_rmw
//   Narrowing store unit. Takes a 32-bit register value and a store size and
//   writes only the selected bytes into word-addressed memory. Word stores go
//   straight to a single write; halfword/byte stores read the word, merge the
//   new lanes (little-endian, byte offset 0 = bits 7:0) and write it back.
//
//   Optional feature macro: ALIGN_CHECK_EN
//     defined   : misaligned requests (halfword with addr[0]=1, word with
//                 addr[1:0]!=0) skip the memory access and finish with err=1.
//     undefined : err is constant 0; misaligned addresses are silently aligned.
//
// Parameters
//   MEM_LAT   memory read latency in cycles (1..7)
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   start     one-cycle request, sampled only in IDLE
//   size      00 word, 01 halfword, 10 byte, 11 word
//   addr      byte address of the store
//   wdata     register data (low byte / low halfword for sub-word stores)
//   mem_dout  memory read data
//   mem_addr  word-aligned memory address
//   mem_din   memory write data
//   mem_wr    memory write strobe, one cycle per operation
//   busy      high in every state except IDLE
//   done      one-cycle completion pulse
//   err       misalignment flag, valid with done
module store_size_rmw #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rd_q;
    logic [31:0] merged_q;
    logic [31:0] merged_next;
    logic [1:0]  size_q;
    logic [2:0]  cnt_reg;
    logic        req_word;
    logic        q_word;

    // Size 11 is treated as a word store.
    assign req_word = (size == 2'b00) || (size == 2'b11);
    assign q_word   = (size_q == 2'b00) || (size_q == 2'b11);

`ifdef ALIGN_CHECK_EN
    logic req_misaligned;
    logic err_q;

    assign req_misaligned = req_word ? (addr[1:0] != 2'b00)
                                     : ((size == 2'b01) && addr[0]);

    // Set at acceptance of a misaligned request, so it is high exactly
    // during the DONE cycle that follows; cleared on the way back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            err_q <= req_misaligned;
        end else if (state_reg == DONE) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Per-lane merge. A lane is replaced when it is the addressed byte
    // (byte store) or part of the addressed halfword (halfword store);
    // halfword lanes take wdata_q[7:0] for even lanes and [15:8] for odd.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic hit;

            assign hit = (size_q == 2'b10) ? (addr_q[1:0] == LANE) :
                         (size_q == 2'b01) ? (addr_q[1] == LANE[1]) : 1'b0;

            assign merged_next[8*gi +: 8] =
                !hit                ? rd_q[8*gi +: 8] :
                (size_q == 2'b10)   ? wdata_q[7:0]    :
                                      wdata_q[8*(gi % 2) +: 8];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
`ifdef ALIGN_CHECK_EN
                    if (req_misaligned) begin
                        state_next = DONE;
                    end else
`endif
                    if (req_word) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ:    if (cnt_reg == LAT_LAST) state_next = MERGE;
            MERGE:   state_next = WRITE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            merged_q  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        addr_q  <= addr;
                        size_q  <= size;
                        wdata_q <= wdata;
                        cnt_reg <= '0;
                    end
                end
                READ: begin
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg == LAT_LAST) begin
                        rd_q <= mem_dout;
                    end
                end
                MERGE:   merged_q <= merged_next;
                default: ;
            endcase
        end
    end

    // All outputs come from state or registered operands only.
    assign mem_addr = {addr_q[31:2], 2'b00};
    assign mem_din  = q_word ? wdata_q : merged_q;
    assign mem_wr   = (state_reg == WRITE);
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_store_size_rmw.sv
// Testbench for store_size_rmw: directed scenarios plus randomized stores
// checked against a byte-array reference model and a behavioural memory.
module tb_store_size_rmw;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_dout;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_wr;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    store_size_rmw #(.MEM_LAT(LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .size     (size),
        .addr     (addr),
        .wdata    (wdata),
        .mem_dout (mem_dout),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_wr   (mem_wr),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Behavioural memory: 64 words indexed by address bits 7:2; read data
    // appears LAT cycles after the address is presented.
    logic [31:0] mem [0:63];
    logic [31:0] apipe [0:7];
    int          wr_count = 0;
    logic [31:0] wr_addr_seen;
    logic [31:0] wr_data_seen;

    always @(posedge clk) begin
        apipe[0] <= mem_addr;
        for (int i = 1; i < 8; i++) apipe[i] <= apipe[i-1];
        if (mem_wr) begin
            mem[mem_addr[7:2]] <= mem_din;
            wr_count     <= wr_count + 1;
            wr_addr_seen <= mem_addr;
            wr_data_seen <= mem_din;
        end
    end

    generate
        if (LAT == 1) begin : g_rd0
            assign mem_dout = mem[mem_addr[7:2]];
        end else begin : g_rdn
            assign mem_dout = mem[apipe[LAT-2][7:2]];
        end
    endgenerate

    // Reference: the word as it should look after the store.
    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
        logic [7:0]  b [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        case (sz)
            2'b10: b[a[1:0]] = wd[7:0];
            2'b01: begin
                b[{a[1], 1'b0}] = wd[7:0];
                b[{a[1], 1'b1}] = wd[15:8];
            end
            default: return wd;
        endcase
        for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    function automatic bit is_misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef ALIGN_CHECK_EN
        if (sz == 2'b01) return a[0];
        if (sz == 2'b10) return 1'b0;
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Issue one request and follow it to done; returns latency in cycles
    // from the accepting edge and err sampled with done.
    task automatic run_op(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic e);
        @(negedge clk);
        start = 1'b1; size = sz; addr = a; wdata = wd;
        @(posedge clk); #1;
        start = 1'b0; size = 2'($urandom); addr = $urandom; wdata = $urandom;
        lat = 1; e = 1'b0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = err;
        @(posedge clk); #1;
    endtask

    // One full store plus every check on it.
    task automatic check_store(input string name, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] wd);
        int          lat, wc0, exp_lat, exp_wc;
        logic        e;
        logic [31:0] exp_word;
        bit          mis;
        mis      = is_misaligned(sz, a);
        exp_word = mis ? mem[a[7:2]] : ref_store(mem[a[7:2]], sz, a, wd);
        exp_lat  = mis ? 1 : ((sz == 2'b01 || sz == 2'b10) ? LAT + 3 : 2);
        exp_wc   = mis ? 0 : 1;
        wc0 = wr_count;
        run_op(sz, a, wd, lat, e);
        n_checks++;
        if (lat !== exp_lat)
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        else n_pass++;
        n_checks++;
        if (wr_count - wc0 !== exp_wc)
            $display("FAIL %s write_pulses: got %0d expected %0d", name, wr_count - wc0, exp_wc);
        else n_pass++;
        n_checks++;
        if (e !== mis)
            $display("FAIL %s err: got %b expected %b", name, e, mis);
        else n_pass++;
        n_checks++;
        if (mem[a[7:2]] !== exp_word)
            $display("FAIL %s mem_word: got %08h expected %08h", name, mem[a[7:2]], exp_word);
        else n_pass++;
        if (!mis) begin
            n_checks++;
            if (wr_addr_seen !== {a[31:2], 2'b00})
                $display("FAIL %s mem_addr: got %08h expected %08h", name, wr_addr_seen, {a[31:2], 2'b00});
            else n_pass++;
        end
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL %s idle_after_done: busy got %b expected 0", name, busy);
        else n_pass++;
        $display("store %-10s size=%b addr=%08h wdata=%08h lat=%0d err=%b word=%08h",
                 name, sz, a, wd, lat, e, mem[a[7:2]]);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({mem_addr, mem_din, mem_wr, busy, done, err} !== 68'd0)
            $display("FAIL reset_outputs: got addr=%08h din=%08h wr=%b busy=%b done=%b err=%b expected all 0",
                     mem_addr, mem_din, mem_wr, busy, done, err);
        else n_pass++;
        $display("reset    outputs addr=%08h din=%08h wr=%b busy=%b done=%b err=%b",
                 mem_addr, mem_din, mem_wr, busy, done, err);
    endtask

    task automatic test_word();
        check_store("word", 2'b00, 32'h0000_0010, 32'hDEAD_BEEF);
    endtask

    task automatic test_byte();
        mem[8] = 32'h1122_3344;
        check_store("byte", 2'b10, 32'h0000_0022, 32'h0000_00AB);
        n_checks++;
        if (mem[8] !== 32'h11AB_3344)
            $display("FAIL byte_value: got %08h expected 11ab3344", mem[8]);
        else n_pass++;
    endtask

    task automatic test_halfword();
        mem[8] = 32'h1122_3344;
        check_store("half", 2'b01, 32'h0000_0020, 32'hFFFF_CAFE);
        n_checks++;
        if (mem[8] !== 32'h1122_CAFE)
            $display("FAIL half_value: got %08h expected 1122cafe", mem[8]);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        mem[8] = 32'h1122_3344;
        check_store("half_mis", 2'b01, 32'h0000_0021, 32'h0000_5A5A);
        check_store("word_mis", 2'b11, 32'h0000_0047, 32'h0BAD_F00D);
    endtask

    task automatic test_busy_start();
        int   wc0, k;
        logic [31:0] exp_word;
        mem[5]   = 32'hA5A5_A5A5;
        exp_word = ref_store(32'hA5A5_A5A5, 2'b10, 32'h0000_0015, 32'h0000_0077);
        wc0 = wr_count;
        @(negedge clk);
        start = 1'b1; size = 2'b10; addr = 32'h0000_0015; wdata = 32'h0000_0077;
        @(negedge clk);
        size = 2'b00; addr = 32'h0000_0014; wdata = 32'h1234_5678;
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        repeat (LAT + 6) @(negedge clk);
        n_checks++;
        if (wr_count - wc0 !== 1)
            $display("FAIL busy_start pulses: got %0d expected 1", wr_count - wc0);
        else n_pass++;
        n_checks++;
        if (wr_data_seen !== exp_word)
            $display("FAIL busy_start data: got %08h expected %08h", wr_data_seen, exp_word);
        else n_pass++;
        $display("busy_start pulses=%0d data=%08h", wr_count - wc0, wr_data_seen);
    endtask

    task automatic test_reset_mid();
        int wc0;
        wc0 = wr_count;
        @(negedge clk);
        start = 1'b1; size = 2'b10; addr = 32'h0000_0030; wdata = 32'h0000_00EE;
        @(posedge clk); #1;
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_addr, mem_din, mem_wr, busy, done, err} !== 68'd0)
            $display("FAIL reset_mid outputs: got addr=%08h din=%08h wr=%b busy=%b done=%b err=%b expected all 0",
                     mem_addr, mem_din, mem_wr, busy, done, err);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        repeat (LAT + 6) @(negedge clk);
        n_checks++;
        if (wr_count - wc0 !== 0 || busy !== 1'b0)
            $display("FAIL reset_mid no_write: got pulses=%0d busy=%b expected 0 0", wr_count - wc0, busy);
        else n_pass++;
        $display("reset_mid pulses=%0d busy=%b", wr_count - wc0, busy);
    endtask

    task automatic test_back_to_back();
        check_store("b2b_a", 2'b10, 32'h0000_0041, 32'h0000_0011);
        check_store("b2b_b", 2'b00, 32'h0000_0050, 32'hCAFE_F00D);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            check_store("random", 2'($urandom), $urandom, $urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        reset = 1'b1; start = 1'b0; size = 2'b00; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_word();
        test_byte();
        test_halfword();
        test_misaligned();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/store_size_rmw.md
Name: store_size_rmw

Overview:
- Narrowing store unit for the multicycle datapath; the store-side counterpart of the 16→32 load sign extension.
- Takes a 32-bit register value and a store size (word/halfword/byte). Writes only the selected bytes into word-addressed memory.
- Sub-word stores use read-modify-write: read the word, merge the new bytes, write the word back.
- Sits between the control unit (start/done handshake) and the memory port.

Parameters:
- MEM_LAT, 1, memory read latency in cycles (1..7); mem_dout is valid MEM_LAT cycles after mem_addr is presented with mem_wr=0.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request from the control unit; sampled only in IDLE
- size  in  2  store size: 00 word, 01 halfword, 10 byte, 11 treated as word
- addr  in  32  byte address of the store
- wdata  in  32  register data; low byte or low halfword used for sub-word stores
- mem_dout  in  32  read data from memory
- mem_addr  out  32  word-aligned address {addr_q[31:2],2'b00}
- mem_din  out  32  write data to memory
- mem_wr  out  1  memory write strobe, one cycle per operation
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  misalignment flag (ALIGN_CHECK_EN only; otherwise tied 0)

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE; all registers clear.
  - mem_addr=0, mem_din=0, mem_wr=0, busy=0, done=0, err=0.
  - A reset mid-operation aborts the operation; mem_wr deasserts immediately with no partial write.
- Output timing: all outputs are decoded from state or held in registers; there are no combinational paths from inputs to outputs.
- States: IDLE, READ, MERGE, WRITE, DONE.
- IDLE:
  - When start=1 at a clock edge, latch addr, size and wdata into addr_q, size_q and wdata_q.
  - Next state is WRITE for word size (00 or 11), otherwise READ.
- READ:
  - mem_wr=0 and mem_addr is stable.
  - A 3-bit counter runs for MEM_LAT cycles.
  - On the last READ cycle, register mem_dout into rd_q, then go to MERGE.
- MERGE (one cycle): build merged_q from rd_q. Byte lanes are little-endian: byte offset 0 is bits 7:0.
  - Byte store: lane addr_q[1:0] is replaced by wdata_q[7:0].
  - Halfword store: lane addr_q[1] is replaced by wdata_q[15:0] (bits 15:0 if addr_q[1]=0, bits 31:16 if addr_q[1]=1).
  - All other bits of rd_q pass through unchanged.
- WRITE (one cycle):
  - mem_wr=1.
  - mem_din is wdata_q for word stores, merged_q for sub-word stores.
  - Next state is DONE.
- DONE (one cycle): done=1, busy still 1, next state is IDLE. A new start is accepted from IDLE on the following cycle.
- Latency from the start-sampling edge to the done pulse:
  - Word: 2 cycles (WRITE, DONE).
  - Sub-word: MEM_LAT+3 cycles (READ×MEM_LAT, MERGE, WRITE, DONE).
- start while busy=1 is ignored; it is neither queued nor does it change the latched operands.
- Input changes on addr, size or wdata after acceptance have no effect on the operation in progress.
- Without ALIGN_CHECK_EN:
  - A word store uses the aligned address and ignores addr[1:0].
  - A halfword store ignores addr[0].

Optional Feature:
- Macro: ALIGN_CHECK_EN.
- When defined, a misaligned request is detected in IDLE at acceptance:
  - Halfword with addr[0]=1, or word with addr[1:0]≠00.
  - The unit goes directly to DONE with no READ and no WRITE, so mem_wr stays 0.
  - err=1 together with done for that one cycle; err clears on return to IDLE.
- When undefined, the check logic is absent, err is a constant 0, and misaligned addresses are silently aligned as described above.

Test Plan:
- Reset mid-operation: assert reset during READ of a byte store → outputs 0 at once, state IDLE, no mem_wr pulse at any point.
- Word store: size=00, addr=0x00000010, wdata=0xDEADBEEF → mem_wr pulses 1 cycle after acceptance with mem_addr=0x10, mem_din=0xDEADBEEF; done 1 cycle later.
- Byte store with MEM_LAT=1: memory word at 0x20 is 0x11223344; size=10, addr=0x22, wdata=0x000000AB → mem_din=0x11AB3344, done 4 cycles after acceptance.
- Halfword store with MEM_LAT=2: memory word at 0x20 is 0x11223344; size=01, addr=0x20, wdata=0xFFFFCAFE → mem_din=0x1122CAFE, done 5 cycles after acceptance.
- start asserted during busy with different operands → ignored; exactly one mem_wr pulse, carrying the first request's data.
- With ALIGN_CHECK_EN: size=01, addr=0x21 → done=1 and err=1 on the same cycle, mem_wr never asserted. Without the macro the same stimulus writes lane 0 (bits 15:0).
